// File: rtl/satd_4x4.sv
// 4x4 SATD engine: row Hadamard pass on the accepting edge, column pass + abs-sum on the next.
// One result every two cycles when init and ack are held high.
module satd_4x4 (
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        ack,
    input  logic [7:0]  a0,
    input  logic [7:0]  a1,
    input  logic [7:0]  a2,
    input  logic [7:0]  a3,
    input  logic [7:0]  a4,
    input  logic [7:0]  a5,
    input  logic [7:0]  a6,
    input  logic [7:0]  a7,
    input  logic [7:0]  a8,
    input  logic [7:0]  a9,
    input  logic [7:0]  a10,
    input  logic [7:0]  a11,
    input  logic [7:0]  a12,
    input  logic [7:0]  a13,
    input  logic [7:0]  a14,
    input  logic [7:0]  a15,
    input  logic [7:0]  b0,
    input  logic [7:0]  b1,
    input  logic [7:0]  b2,
    input  logic [7:0]  b3,
    input  logic [7:0]  b4,
    input  logic [7:0]  b5,
    input  logic [7:0]  b6,
    input  logic [7:0]  b7,
    input  logic [7:0]  b8,
    input  logic [7:0]  b9,
    input  logic [7:0]  b10,
    input  logic [7:0]  b11,
    input  logic [7:0]  b12,
    input  logic [7:0]  b13,
    input  logic [7:0]  b14,
    input  logic [7:0]  b15,
    output logic [15:0] result,
    output logic        done,
    output logic [1:0]  state_dbg
);

    // Handshake: a block is accepted on an edge where init=1 and the engine is
    // in IDLE, or in DONE with ack=1. done stays high until the edge where ack=1.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef logic signed [12:0] coef_t;

    state_t r_state;
    state_t w_next_state;
    logic   w_capture;
    logic   w_finish;

    logic [7:0]        w_a   [16];
    logic [7:0]        w_b   [16];
    logic signed [8:0] w_d   [16];
    coef_t             w_row [16];
    coef_t             w_col [16];
    logic [15:0]       w_sum;

    logic signed [10:0] r_row [16];
    logic [15:0]        r_result;
    logic               r_done;

    function automatic void bfly(
        input  coef_t x0,
        input  coef_t x1,
        input  coef_t x2,
        input  coef_t x3,
        output coef_t y0,
        output coef_t y1,
        output coef_t y2,
        output coef_t y3
    );
        coef_t s0;
        coef_t s1;
        coef_t s2;
        coef_t s3;
        s0 = x0 + x1;
        s1 = x0 - x1;
        s2 = x2 + x3;
        s3 = x2 - x3;
        y0 = s0 + s2;
        y1 = s1 + s3;
        y2 = s0 - s2;
        y3 = s1 - s3;
    endfunction

    always_comb begin
        w_a = '{a0, a1, a2, a3, a4, a5, a6, a7, a8, a9, a10, a11, a12, a13, a14, a15};
        w_b = '{b0, b1, b2, b3, b4, b5, b6, b7, b8, b9, b10, b11, b12, b13, b14, b15};
    end

    // Row pass works in 13 bits; results fit in 11 bits (|y| <= 1020) so the
    // registered copy keeps only the low 11.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_d[i] = {1'b0, w_a[i]} - {1'b0, w_b[i]};
        end
        for (int r = 0; r < 4; r++) begin
            bfly({{4{w_d[4*r][8]}},   w_d[4*r]},
                 {{4{w_d[4*r+1][8]}}, w_d[4*r+1]},
                 {{4{w_d[4*r+2][8]}}, w_d[4*r+2]},
                 {{4{w_d[4*r+3][8]}}, w_d[4*r+3]},
                 w_row[4*r], w_row[4*r+1], w_row[4*r+2], w_row[4*r+3]);
        end
    end

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            bfly({{2{r_row[c][10]}},    r_row[c]},
                 {{2{r_row[4+c][10]}},  r_row[4+c]},
                 {{2{r_row[8+c][10]}},  r_row[8+c]},
                 {{2{r_row[12+c][10]}}, r_row[12+c]},
                 w_col[c], w_col[4+c], w_col[8+c], w_col[12+c]);
        end
    end

    // |coef| <= 4080, so the 13-bit negation never overflows.
    always_comb begin
        coef_t v_abs;
        w_sum = '0;
        for (int i = 0; i < 16; i++) begin
            v_abs = w_col[i][12] ? -w_col[i] : w_col[i];
            w_sum = w_sum + {3'b000, v_abs};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (init) begin
                    w_capture    = 1'b1;
                    w_next_state = S_CALC;
                end
            end
            S_CALC: begin
                w_finish     = 1'b1;
                w_next_state = S_DONE;
            end
            S_DONE: begin
                if (ack) begin
                    if (init) begin
                        w_capture    = 1'b1;
                        w_next_state = S_CALC;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                r_row[i] <= '0;
            end
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            if (w_capture) begin
                for (int i = 0; i < 16; i++) begin
                    r_row[i] <= w_row[i][10:0];
                end
            end
            if (w_finish) begin
                r_result <= w_sum;
            end
            r_done <= (w_next_state == S_DONE);
        end
    end

    assign result    = r_result;
    assign done      = r_done;
    assign state_dbg = r_state;

endmodule

// File: tb/tb_satd_4x4.sv
// Directed bench for satd_4x4: hand-computed SATD values, latency, handshake and reset checks.
module tb_satd_4x4;

    logic        clk;
    logic        reset;
    logic        init;
    logic        ack;
    logic [7:0]  a [16];
    logic [7:0]  b [16];
    logic [15:0] result;
    logic        done;
    logic [1:0]  state_dbg;

    int n_tests;
    int n_fail;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    satd_4x4 dut (
        .clk(clk), .reset(reset), .init(init), .ack(ack),
        .a0(a[0]),   .a1(a[1]),   .a2(a[2]),   .a3(a[3]),
        .a4(a[4]),   .a5(a[5]),   .a6(a[6]),   .a7(a[7]),
        .a8(a[8]),   .a9(a[9]),   .a10(a[10]), .a11(a[11]),
        .a12(a[12]), .a13(a[13]), .a14(a[14]), .a15(a[15]),
        .b0(b[0]),   .b1(b[1]),   .b2(b[2]),   .b3(b[3]),
        .b4(b[4]),   .b5(b[5]),   .b6(b[6]),   .b7(b[7]),
        .b8(b[8]),   .b9(b[9]),   .b10(b[10]), .b11(b[11]),
        .b12(b[12]), .b13(b[13]), .b14(b[14]), .b15(b[15]),
        .result(result), .done(done), .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [7:0] av, input logic [7:0] bv);
        for (int i = 0; i < 16; i++) begin
            a[i] = av;
            b[i] = bv;
        end
    endtask

    // block ids: 0 = DC 160, 1 = impulse 4080
    task automatic load_block(input int id);
        if (id == 0) begin
            fill(8'd10, 8'd0);
        end else begin
            fill(8'd0, 8'd0);
            a[0] = 8'd255;
        end
    endtask

    task automatic run_one(input string tag, input int exp);
        int cycles;
        init = 1'b1;
        tick();
        init = 1'b0;
        cycles = 1;
        while (!done && cycles < 6) begin
            tick();
            cycles++;
        end
        check({tag, "_lat"}, cycles, 2);
        check(tag, result, exp);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check({tag, "_ack"}, done, 0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        init  = 1'b0;
        ack   = 1'b0;
        fill(8'd0, 8'd0);
        repeat (3) tick();
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_state", state_dbg, ST_IDLE);
        reset = 1'b0;
        repeat (2) tick();
        check("idle_done", done, 0);
        check("idle_state", state_dbg, ST_IDLE);

        // DC block, then hold behaviour while ack is low
        fill(8'd10, 8'd0);
        init = 1'b1;
        tick();
        init = 1'b0;
        check("dc_calc_done", done, 0);
        check("dc_calc_state", state_dbg, ST_CALC);
        tick();
        check("dc_done", done, 1);
        check("dc_result", result, 160);
        fill(8'd0, 8'd0);
        a[0] = 8'd255;
        init = 1'b1;
        repeat (2) tick();
        check("dc_hold_done", done, 1);
        check("dc_hold_result", result, 160);
        check("dc_hold_state", state_dbg, ST_DONE);
        init = 1'b0;
        ack  = 1'b1;
        tick();
        ack = 1'b0;
        check("dc_ack_done", done, 0);
        check("dc_ack_state", state_dbg, ST_IDLE);
        tick();
        check("idle_keep_result", result, 160);

        fill(8'd0, 8'd0);
        a[0] = 8'd255;
        run_one("imp_pos", 4080);
        fill(8'd0, 8'd255);
        run_one("imp_neg", 4080);
        for (int i = 0; i < 16; i++) begin
            a[i] = 8'(17 * i);
            b[i] = 8'(17 * i);
        end
        run_one("equal", 0);
        fill(8'd0, 8'd0);
        a[0] = 8'd1;
        a[1] = 8'd2;
        run_one("pair12", 32);
        fill(8'd0, 8'd0);
        a[0] = 8'd1;
        b[1] = 8'd1;
        run_one("pair_pm", 16);
        fill(8'd0, 8'd0);
        for (int i = 0; i < 16; i++) begin
            if ((((i / 4) + (i % 4)) % 2) == 0) a[i] = 8'd255;
        end
        run_one("checker", 4080);

        // back-to-back with init and ack held high
        load_block(0);
        init = 1'b1;
        ack  = 1'b1;
        tick();
        check("b2b_first_calc", done, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("b2b_done_%0d", k), done, 1);
            check($sformatf("b2b_result_%0d", k), result, (k % 2 == 0) ? 160 : 4080);
            load_block((k + 1) % 2);
            tick();
            check($sformatf("b2b_gap_%0d", k), done, 0);
        end
        init = 1'b0;
        tick();
        check("b2b_last_done", done, 1);
        check("b2b_last_result", result, 160);
        tick();
        ack = 1'b0;
        check("b2b_end_done", done, 0);
        check("b2b_end_state", state_dbg, ST_IDLE);

        // reset in CALC
        load_block(1);
        init = 1'b1;
        tick();
        init  = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_calc_done", done, 0);
        check("rst_calc_result", result, 0);
        check("rst_calc_state", state_dbg, ST_IDLE);

        // reset in DONE
        init = 1'b1;
        repeat (2) tick();
        init = 1'b0;
        check("pre_rst_done", done, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_done_done", done, 0);
        check("rst_done_result", result, 0);
        check("rst_done_state", state_dbg, ST_IDLE);

        // ack with nothing pending
        ack = 1'b1;
        repeat (2) tick();
        ack = 1'b0;
        check("stray_ack_done", done, 0);
        check("stray_ack_state", state_dbg, ST_IDLE);
        check("stray_ack_result", result, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
